mixcol_seq: RTL and testbench

- Sequences one shared wordmixcol instance across the four 32-bit columns of a 128-bit AES state.
- Processes one column per clock and returns the full mixed (or inverse-mixed) state through a valid/ready handshake.
- Sits between the round-state register and AddRoundKey in the iterative round datapath, and trades 3 extra cycles per round for 3 fewer column-mix instances.

---
 rtl/mixcol_seq.sv | 167 ++++++++++++++++
 tb/tb_mixcol_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mixcol_seq.sv
// Iterative AES (Inv)MixColumns: one shared column mixer walks the four
// columns of a 128-bit state, one column per clock, behind valid/ready.

module wordmixcol (
    input  logic [31:0] col_i,
    output logic [31:0] en_new_out,
    output logic [31:0] de_new_out
);
    function automatic logic [7:0] xt(input logic [7:0] b);
        xt = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] a  [4];

    assign a0 = col_i[31:24];
    assign a1 = col_i[23:16];
    assign a2 = col_i[15:8];
    assign a3 = col_i[7:0];
    assign a[0] = a0;
    assign a[1] = a1;
    assign a[2] = a2;
    assign a[3] = a3;

    // Doubling chain shared by forward and inverse coefficients
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            x2[i] = xt(a[i]);
            x4[i] = xt(x2[i]);
            x8[i] = xt(x4[i]);
        end
    end

    // 3a = 2a^a, 9a = 8a^a, 11a = 8a^2a^a, 13a = 8a^4a^a, 14a = 8a^4a^2a
    assign en_new_out[31:24] = x2[0] ^ (x2[1] ^ a1) ^ a2 ^ a3;
    assign en_new_out[23:16] = a0 ^ x2[1] ^ (x2[2] ^ a2) ^ a3;
    assign en_new_out[15:8]  = a0 ^ a1 ^ x2[2] ^ (x2[3] ^ a3);
    assign en_new_out[7:0]   = (x2[0] ^ a0) ^ a1 ^ a2 ^ x2[3];

    assign de_new_out[31:24] = (x8[0] ^ x4[0] ^ x2[0]) ^ (x8[1] ^ x2[1] ^ a1)
                             ^ (x8[2] ^ x4[2] ^ a2) ^ (x8[3] ^ a3);
    assign de_new_out[23:16] = (x8[0] ^ a0) ^ (x8[1] ^ x4[1] ^ x2[1])
                             ^ (x8[2] ^ x2[2] ^ a2) ^ (x8[3] ^ x4[3] ^ a3);
    assign de_new_out[15:8]  = (x8[0] ^ x4[0] ^ a0) ^ (x8[1] ^ a1)
                             ^ (x8[2] ^ x4[2] ^ x2[2]) ^ (x8[3] ^ x2[3] ^ a3);
    assign de_new_out[7:0]   = (x8[0] ^ x2[0] ^ a0) ^ (x8[1] ^ x4[1] ^ a1)
                             ^ (x8[2] ^ a2) ^ (x8[3] ^ x4[3] ^ x2[3]);
endmodule

module mixcol_seq #(
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic         mode,
    input  logic         bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [127:0] work_q, work_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         mode_q, mode_d;
    logic         bypass_q, bypass_d;
    logic [31:0]  col_s, en_s, de_s, mixed_s;

    // Column feeding the shared mixer
    always_comb begin
        case (cnt_q)
            2'd0:    col_s = work_q[127:96];
            2'd1:    col_s = work_q[95:64];
            2'd2:    col_s = work_q[63:32];
            2'd3:    col_s = work_q[31:0];
            default: col_s = 32'h0000_0000;
        endcase
    end

    wordmixcol u_mix (
        .col_i      (col_s),
        .en_new_out (en_s),
        .de_new_out (de_s)
    );

    assign mixed_s = mode_q ? de_s : en_s;

    // Next-state, capture and column write-back
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        bypass_d = bypass_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    work_d   = state_in;
                    mode_d   = mode;
                    bypass_d = bypass & BYPASS_EN;
                    cnt_d    = 2'd0;
                    state_d  = (bypass & BYPASS_EN) ? S_DONE : S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                case (cnt_q)
                    2'd0:    work_d[127:96] = mixed_s;
                    2'd1:    work_d[95:64]  = mixed_s;
                    2'd2:    work_d[63:32]  = mixed_s;
                    2'd3:    work_d[31:0]   = mixed_s;
                    default: work_d         = work_q;
                endcase
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            work_q   <= 128'h0;
            cnt_q    <= 2'd0;
            mode_q   <= 1'b0;
            bypass_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            bypass_q <= bypass_d;
        end
    end

    // Partial results in RUN are never exposed on state_out
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign state_out = out_valid ? work_q : 128'h0;
endmodule

// File: tb/tb_mixcol_seq.sv
// Self-checking bench for mixcol_seq: GF(2^8) matrix model plus directed vectors.

module tb_mixcol_seq;
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, mode, bypass, out_ready;
    logic [127:0] state_in;
    logic         in_ready, out_valid, busy;
    logic [127:0] state_out;

    logic         in_valid_b, mode_b, bypass_b, out_ready_b;
    logic [127:0] state_in_b;
    logic         in_ready_b, out_valid_b, busy_b;
    logic [127:0] state_out_b;

    int           n_pass = 0;
    int           n_checks = 0;
    logic [127:0] exp_state = 128'h0;
    logic         toggle = 1'b0;

    localparam logic [127:0] ENC_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] ENC_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] RST_IN  = 128'h01010101_c6c6c6c6_d4d4d4d5_2d26314c;
    localparam logic [127:0] RST_OUT = 128'h01010101_c6c6c6c6_d5d5d7d6_4d7ebdf8;
    localparam logic [127:0] BYP_IN  = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] PEND_IN = 128'hd4d4d4d5_2d26314c_db135345_f20a225c;

    always #5 clk = ~clk;

    mixcol_seq #(.BYPASS_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .state_in(state_in), .mode(mode), .bypass(bypass),
        .out_valid(out_valid), .out_ready(out_ready),
        .state_out(state_out), .busy(busy)
    );

    mixcol_seq #(.BYPASS_EN(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .state_in(state_in_b), .mode(mode_b), .bypass(bypass_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .state_out(state_out_b), .busy(busy_b)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Textbook circulant matrix: row r uses coefficient base[(k-r) mod 4] for byte k
    function automatic logic [127:0] model(input logic [127:0] s, input logic inv, input logic byp);
        logic [7:0]   base [4];
        logic [7:0]   col  [4];
        logic [7:0]   acc;
        logic [127:0] r = 128'h0;
        if (byp) return s;
        if (inv) begin base[0] = 8'd14; base[1] = 8'd11; base[2] = 8'd13; base[3] = 8'd9; end
        else     begin base[0] = 8'd2;  base[1] = 8'd3;  base[2] = 8'd1;  base[3] = 8'd1; end
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) col[k] = s[127 - 32*c - 8*k -: 8];
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc = acc ^ gmul(col[k], base[(k - row + 4) % 4]);
                r[127 - 32*c - 8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    // Continuous compare against the model
    always @(negedge clk) begin
        if (!rst) begin
            check("ready_vs_busy", {127'h0, in_ready}, {127'h0, ~busy});
            if (out_valid) check("state_out_model", state_out, exp_state);
        end
    end

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (toggle) begin
                state_in = ~state_in ^ {4{32'h5a5a_1234}};
                mode     = ~mode;
            end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic accept(input logic [127:0] s, input logic m, input logic b, output int lat);
        int guard = 0;
        while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
        state_in = s; mode = m; bypass = b; in_valid = 1'b1;
        exp_state = model(s, m, b);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [127:0] held;
        rst = 1'b1; in_valid = 1'b0; mode = 1'b0; bypass = 1'b0; out_ready = 1'b1;
        state_in = 128'h0;
        in_valid_b = 1'b0; mode_b = 1'b0; bypass_b = 1'b0; out_ready_b = 1'b1;
        state_in_b = 128'h0;

        // Pin the model with hand-known vectors
        check("model_enc", model(ENC_IN, 1'b0, 1'b0), ENC_OUT);
        check("model_dec", model(ENC_OUT, 1'b1, 1'b0), ENC_IN);
        check("model_rst_vec", model(RST_IN, 1'b0, 1'b0), RST_OUT);

        #12;
        check("reset_in_ready", {127'h0, in_ready}, 128'h1);
        check("reset_out_valid", {127'h0, out_valid}, 128'h0);
        check("reset_busy", {127'h0, busy}, 128'h0);
        check("reset_state_out", state_out, 128'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset during the second RUN cycle
        state_in = ENC_IN; mode = 1'b0; bypass = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; #1;
        check("midrst_out_valid", {127'h0, out_valid}, 128'h0);
        check("midrst_in_ready", {127'h0, in_ready}, 128'h1);
        check("midrst_state_out", state_out, 128'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        accept(RST_IN, 1'b0, 1'b0, lat);
        check("postrst_latency", 128'(lat), 128'd4);
        check("postrst_result", state_out, RST_OUT);
        @(posedge clk); #1;

        // Encrypt
        accept(ENC_IN, 1'b0, 1'b0, lat);
        check("enc_latency", 128'(lat), 128'd4);
        check("enc_result", state_out, ENC_OUT);
        @(posedge clk); #1;
        check("enc_after_valid", {127'h0, out_valid}, 128'h0);
        check("enc_after_ready", {127'h0, in_ready}, 128'h1);

        // Decrypt
        accept(ENC_OUT, 1'b1, 1'b0, lat);
        check("dec_latency", 128'(lat), 128'd4);
        check("dec_result", state_out, ENC_IN);
        @(posedge clk); #1;

        // Bypass
        accept(BYP_IN, 1'b0, 1'b1, lat);
        check("byp_latency", 128'(lat), 128'd0);
        check("byp_result", state_out, BYP_IN);
        @(posedge clk); #1;

        // Inputs toggled every cycle during RUN
        toggle = 1'b1;
        accept(ENC_OUT, 1'b1, 1'b0, lat);
        toggle = 1'b0;
        check("toggle_latency", 128'(lat), 128'd4);
        check("toggle_result", state_out, ENC_IN);
        @(posedge clk); #1;

        // Backpressure with a pending input
        out_ready = 1'b0;
        accept(ENC_IN, 1'b0, 1'b0, lat);
        check("bp_latency", 128'(lat), 128'd4);
        held = state_out;
        state_in = PEND_IN; mode = 1'b0; bypass = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_stable", state_out, ENC_OUT);
            check("bp_in_ready", {127'h0, in_ready}, 128'h0);
            check("bp_out_valid", {127'h0, out_valid}, 128'h1);
        end
        check("bp_held", held, ENC_OUT);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", {127'h0, out_valid}, 128'h0);
        check("bp_release_ready", {127'h0, in_ready}, 128'h1);
        exp_state = model(PEND_IN, 1'b0, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("pend_accepted", {127'h0, busy}, 128'h1);
        wait_valid(lat);
        check("pend_latency", 128'(lat), 128'd4);
        check("pend_result", state_out, model(PEND_IN, 1'b0, 1'b0));
        @(posedge clk); #1;

        // Bypass request ignored when the feature is disabled
        state_in_b = ENC_IN; mode_b = 1'b0; bypass_b = 1'b1; in_valid_b = 1'b1;
        @(posedge clk); #1;
        in_valid_b = 1'b0;
        lat = 0;
        while (!out_valid_b && lat < 20) begin @(posedge clk); #1; lat++; end
        check("nobyp_latency", 128'(lat), 128'd4);
        check("nobyp_result", state_out_b, ENC_OUT);
        check("nobyp_busy", {127'h0, busy_b}, 128'h1);
        @(posedge clk); #1;
        check("nobyp_ready", {127'h0, in_ready_b}, 128'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
